// File: rtl/riscv_alu_serdiv_ext_if.sv
// Request/result handshake bundle for the serial divider.
// The master side issues operations; the slave side is the divider.
interface riscv_alu_serdiv_ext_if #(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_TAG_WIDTH = 5
);
  logic [C_WIDTH-1:0]     OpA_DI;
  logic [C_WIDTH-1:0]     OpB_DI;
  logic [1:0]             OpCode_SI;
  logic [C_TAG_WIDTH-1:0] Tag_DI;
  logic                   InVld_SI;
  logic                   InRdy_SO;
  logic                   Flush_SI;
  logic                   OutVld_SO;
  logic                   OutRdy_SI;
  logic [C_WIDTH-1:0]     Res_DO;
  logic [C_TAG_WIDTH-1:0] Tag_DO;

  modport master (
    output OpA_DI, OpB_DI, OpCode_SI, Tag_DI,
    output InVld_SI, Flush_SI, OutRdy_SI,
    input  InRdy_SO, OutVld_SO, Res_DO, Tag_DO
  );

  modport slave (
    input  OpA_DI, OpB_DI, OpCode_SI, Tag_DI,
    input  InVld_SI, Flush_SI, OutRdy_SI,
    output InRdy_SO, OutVld_SO, Res_DO, Tag_DO
  );
endinterface

// File: rtl/riscv_alu_serdiv_ext.sv
// Serial restoring divider, one quotient bit per cycle.
// Aligns the divisor from leading-zero counts and early-outs trivial cases.
module riscv_alu_serdiv_ext #(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_WIDTH = $clog2(C_WIDTH+1),
  parameter int unsigned C_TAG_WIDTH = 5
) (
  input logic                   Clk_CI,
  input logic                   Rst_RBI,
  riscv_alu_serdiv_ext_if.slave Bus
);

  if (C_LOG_WIDTH != $clog2(C_WIDTH+1)) begin : gen_bad_log
    $error("C_LOG_WIDTH must equal clog2(C_WIDTH+1)");
  end
  if (C_WIDTH < 8 || C_WIDTH > 64) begin : gen_bad_width
    $error("C_WIDTH must lie in 8..64");
  end

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } state_e;

  state_e State_SP, State_SN;

  logic [C_WIDTH-1:0]     Rem_DP;
  logic [C_WIDTH-1:0]     Div_DP;
  logic [C_WIDTH-1:0]     Quo_DP;
  logic [C_LOG_WIDTH-1:0] Cnt_DP;
  logic [C_TAG_WIDTH-1:0] Tag_DP;
  logic                   RemSel_SP;
  logic                   NegQ_SP;
  logic                   NegR_SP;

  logic                   isSigned;
  logic                   negA;
  logic                   negB;
  logic                   bZero;
  logic [C_WIDTH-1:0]     absA;
  logic [C_WIDTH-1:0]     absB;
  logic [C_LOG_WIDTH-1:0] lzcA;
  logic [C_LOG_WIDTH-1:0] lzcB;
  logic [C_LOG_WIDTH-1:0] shAmt;
  logic                   early;
  logic                   accept;
  logic                   geq;
  logic [C_WIDTH-1:0]     resRaw;
  logic                   resNeg;

  function automatic logic [C_LOG_WIDTH-1:0] lzc(
    input logic [C_WIDTH-1:0] v
  );
    lzc = C_LOG_WIDTH'(C_WIDTH);
    for (int i = 0; i < int'(C_WIDTH); i++) begin
      if (v[i]) lzc = C_LOG_WIDTH'(int'(C_WIDTH) - 1 - i);
    end
  endfunction

  always_comb begin
    isSigned = Bus.OpCode_SI[0];
    negA     = isSigned & Bus.OpA_DI[C_WIDTH-1];
    negB     = isSigned & Bus.OpB_DI[C_WIDTH-1];
    absA     = negA ? -Bus.OpA_DI : Bus.OpA_DI;
    absB     = negB ? -Bus.OpB_DI : Bus.OpB_DI;
    bZero    = (Bus.OpB_DI == '0);
    lzcA     = lzc(absA);
    lzcB     = lzc(absB);
    shAmt    = lzcB - lzcA;
    // |A| = 0 gives lzcA = C_WIDTH, so it also lands here
    early    = bZero | (lzcA > lzcB);
  end

  assign accept = Bus.InVld_SI & (State_SP == IDLE) & ~Bus.Flush_SI;
  assign geq    = (Rem_DP >= Div_DP);

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) State_SP <= IDLE;
    else          State_SP <= State_SN;
  end

  always_comb begin
    State_SN = State_SP;
    unique case (State_SP)
      IDLE:    if (accept) State_SN = early ? FINISH : DIVIDE;
      DIVIDE:  if (Cnt_DP == '0) State_SN = FINISH;
      FINISH:  if (Bus.OutRdy_SI) State_SN = IDLE;
      default: State_SN = IDLE;
    endcase
    if (Bus.Flush_SI) State_SN = IDLE;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      Rem_DP    <= '0;
      Div_DP    <= '0;
      Quo_DP    <= '0;
      Cnt_DP    <= '0;
      Tag_DP    <= '0;
      RemSel_SP <= 1'b0;
      NegQ_SP   <= 1'b0;
      NegR_SP   <= 1'b0;
    end else if (accept) begin
      Tag_DP    <= Bus.Tag_DI;
      RemSel_SP <= Bus.OpCode_SI[1];
      NegQ_SP   <= isSigned & (Bus.OpA_DI[C_WIDTH-1] ^ Bus.OpB_DI[C_WIDTH-1]) & ~bZero;
      NegR_SP   <= negA;
      Rem_DP    <= absA;
      Quo_DP    <= bZero ? '1 : '0;
      Div_DP    <= absB << shAmt;
      Cnt_DP    <= shAmt;
    end else if (State_SP == DIVIDE) begin
      if (geq) Rem_DP <= Rem_DP - Div_DP;
      Quo_DP <= {Quo_DP[C_WIDTH-2:0], geq};
      Div_DP <= Div_DP >> 1;
      Cnt_DP <= Cnt_DP - C_LOG_WIDTH'(1);
    end
  end

  always_comb begin
    resRaw     = RemSel_SP ? Rem_DP : Quo_DP;
    resNeg     = RemSel_SP ? NegR_SP : NegQ_SP;
    Bus.Res_DO = resNeg ? -resRaw : resRaw;
  end

  assign Bus.Tag_DO    = Tag_DP;
  assign Bus.InRdy_SO  = (State_SP == IDLE);
  assign Bus.OutVld_SO = (State_SP == FINISH);

endmodule

// File: tb/tb_riscv_alu_serdiv_ext.sv
// Directed plus random checks of the serial divider against
// a plain-arithmetic reference with spec-derived latency.
module tb_riscv_alu_serdiv_ext;

  logic clk;
  logic rstN;
  int   nPass;
  int   nTotal;

  riscv_alu_serdiv_ext_if #(.C_WIDTH(32), .C_TAG_WIDTH(5)) bus ();

  riscv_alu_serdiv_ext #(
    .C_WIDTH(32),
    .C_TAG_WIDTH(5)
  ) dut (
    .Clk_CI(clk),
    .Rst_RBI(rstN),
    .Bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nTotal++;
    assert (got === exp) nPass++;
    else $error("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic int lz(input logic [31:0] v);
    int n = 32;
    for (int i = 0; i < 32; i++) if (v[i]) n = 31 - i;
    return n;
  endfunction

  function automatic logic [31:0] refRes(input logic [31:0] a, b, input logic [1:0] op);
    longint sa, sb, q, r;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return op[1] ? r[31:0] : q[31:0];
    end
    return op[1] ? a % b : a / b;
  endfunction

  function automatic int refLat(input logic [31:0] a, b, input logic [1:0] op);
    logic [31:0] ma, mb;
    int s;
    if (b == 0) return 1;
    ma = (op[0] && a[31]) ? -a : a;
    mb = (op[0] && b[31]) ? -b : b;
    if (ma == 0) return 1;
    s = lz(mb) - lz(ma);
    return (s < 0) ? 1 : s + 2;
  endfunction

  task automatic doOp(input logic [31:0] a, b, input logic [1:0] op,
                      input logic [4:0] tg, input string nm, input int hold);
    logic [31:0] expR;
    int expL;
    int n;
    expR = refRes(a, b, op);
    expL = refLat(a, b, op);
    @(negedge clk);
    bus.OpA_DI    = a;
    bus.OpB_DI    = b;
    bus.OpCode_SI = op;
    bus.Tag_DI    = tg;
    bus.InVld_SI  = 1'b1;
    chk({nm, " inrdy"}, 64'(bus.InRdy_SO), 64'(1));
    @(posedge clk);
    #1;
    bus.InVld_SI  = 1'b0;
    bus.OpA_DI    = $urandom;
    bus.OpB_DI    = $urandom;
    bus.OpCode_SI = 2'($urandom);
    bus.Tag_DI    = 5'($urandom);
    n = 1;
    while (!bus.OutVld_SO && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " lat"}, 64'(n), 64'(expL));
    chk({nm, " res"}, 64'(bus.Res_DO), 64'(expR));
    chk({nm, " tag"}, 64'(bus.Tag_DO), 64'(tg));
    if (!bus.OutVld_SO) begin
      @(negedge clk);
      bus.Flush_SI = 1'b1;
      @(posedge clk);
      #1;
      bus.Flush_SI = 1'b0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.InVld_SI = 1'b1;
      bus.OpA_DI   = $urandom;
      chk({nm, " hold res"}, 64'(bus.Res_DO), 64'(expR));
      chk({nm, " hold tag"}, 64'(bus.Tag_DO), 64'(tg));
      chk({nm, " hold rdy"}, 64'({bus.OutVld_SO, bus.InRdy_SO}), 64'(2'b10));
    end
    @(negedge clk);
    bus.OutRdy_SI = 1'b1;
    @(posedge clk);
    #1;
    bus.OutRdy_SI = 1'b0;
    bus.InVld_SI  = 1'b0;
    chk({nm, " idle"}, 64'({bus.OutVld_SO, bus.InRdy_SO}), 64'(2'b01));
  endtask

  initial begin
    int seen;
    logic [31:0] ra, rb;
    nPass  = 0;
    nTotal = 0;
    rstN   = 1'b0;
    bus.OpA_DI    = '0;
    bus.OpB_DI    = '0;
    bus.OpCode_SI = '0;
    bus.Tag_DI    = '0;
    bus.InVld_SI  = 1'b0;
    bus.Flush_SI  = 1'b0;
    bus.OutRdy_SI = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 64'({bus.InRdy_SO, bus.OutVld_SO, bus.Res_DO, bus.Tag_DO}),
        64'({1'b1, 1'b0, 32'd0, 5'd0}));
    @(negedge clk);
    rstN = 1'b1;

    doOp(32'd100, 32'd7, 2'd0, 5'd3, "divu100/7", 0);
    doOp(32'd100, 32'd7, 2'd2, 5'd4, "remu100/7", 0);
    doOp(32'hFFFF_FFF9, 32'd2, 2'd1, 5'd5, "div-7/2", 0);
    doOp(32'hFFFF_FFF9, 32'd2, 2'd3, 5'd6, "rem-7/2", 0);
    doOp(32'd7, 32'hFFFF_FFFE, 2'd1, 5'd7, "div7/-2", 0);
    doOp(32'd7, 32'hFFFF_FFFE, 2'd3, 5'd8, "rem7/-2", 0);
    doOp(32'h1234, 32'd0, 2'd0, 5'd9, "divu/0", 0);
    doOp(32'h1234, 32'd0, 2'd3, 5'd10, "rem/0", 0);
    doOp(32'hFFFF_FFFB, 32'd0, 2'd1, 5'd11, "div-5/0", 0);
    doOp(32'h8000_0000, 32'hFFFF_FFFF, 2'd1, 5'd12, "divovf", 0);
    doOp(32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 5'd13, "removf", 0);
    doOp(32'hFFFF_FFFF, 32'd1, 2'd0, 5'd14, "divumax/1", 0);
    doOp(32'd3, 32'd10, 2'd0, 5'd15, "divu3/10", 0);
    doOp(32'd3, 32'd10, 2'd2, 5'd16, "remu3/10", 4);
    doOp(32'd21, 32'd4, 2'd0, 5'd17, "b2b", 0);
    doOp(32'd0, 32'd5, 2'd1, 5'd18, "div0/5", 0);

    // flush on the third DIVIDE cycle of divu 1000/3
    @(negedge clk);
    bus.OpA_DI    = 32'd1000;
    bus.OpB_DI    = 32'd3;
    bus.OpCode_SI = 2'd0;
    bus.Tag_DI    = 5'd19;
    bus.InVld_SI  = 1'b1;
    @(posedge clk);
    #1;
    bus.InVld_SI = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.Flush_SI = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush_SI = 1'b0;
    chk("flush idle", 64'({bus.OutVld_SO, bus.InRdy_SO}), 64'(2'b01));
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.OutVld_SO) seen++;
    end
    chk("flush noout", 64'(seen), 64'(0));
    doOp(32'd9, 32'd3, 2'd0, 5'd20, "divu9/3", 0);

    // flush together with a request in IDLE
    @(negedge clk);
    bus.OpA_DI    = 32'd50;
    bus.OpB_DI    = 32'd60;
    bus.InVld_SI  = 1'b1;
    bus.Flush_SI  = 1'b1;
    @(posedge clk);
    #1;
    bus.InVld_SI = 1'b0;
    bus.Flush_SI = 1'b0;
    chk("flushreq rdy", 64'({bus.OutVld_SO, bus.InRdy_SO}), 64'(2'b01));
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.OutVld_SO) seen++;
    end
    chk("flushreq noout", 64'(seen), 64'(0));

    // asynchronous reset in the middle of a long divide
    @(negedge clk);
    bus.OpA_DI    = 32'hFFFF_FFFF;
    bus.OpB_DI    = 32'd1;
    bus.OpCode_SI = 2'd0;
    bus.Tag_DI    = 5'd21;
    bus.InVld_SI  = 1'b1;
    @(posedge clk);
    #1;
    bus.InVld_SI = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rstN = 1'b0;
    #1;
    chk("async rst", 64'({bus.InRdy_SO, bus.OutVld_SO, bus.Res_DO, bus.Tag_DO}),
        64'({1'b1, 1'b0, 32'd0, 5'd0}));
    @(negedge clk);
    rstN = 1'b1;
    doOp(32'd77, 32'd11, 2'd0, 5'd22, "post rst", 0);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) == 0) ra = ra >> $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = $urandom;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 3) == 0) rb = -rb;
      doOp(ra, rb, 2'($urandom), 5'($urandom), $sformatf("rnd%0d", i),
           int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

// File: doc/riscv_alu_serdiv_ext.md
Name: riscv_alu_serdiv_ext

Overview:
Parametrised serial integer divider for the RISC-V ALU. It is the next generation of the team's one-bit-per-cycle signed/unsigned divider.
- Computes operand magnitudes and the alignment shift internally from leading-zero counts; the decoder no longer supplies them.
- Early-outs on a zero divisor and on |A| < |B|.
- Carries a caller tag, supports flush, and exposes a full valid/ready handshake on both sides.
- Sits beside the multiplier in the EX stage and is driven by the ALU operand muxes.

Parameters:
C_WIDTH, 32, operand and result width in bits (8..64).
C_LOG_WIDTH, $clog2(C_WIDTH+1), counter width; elaboration error if any other value is given.
C_TAG_WIDTH, 5, width of the opaque tag (destination register id).

Ports:
Clk_CI  in  1  clock, rising edge.
Rst_RBI  in  1  reset; asynchronous, active-low.
OpA_DI  in  C_WIDTH  dividend.
OpB_DI  in  C_WIDTH  divisor.
OpCode_SI  in  2  0: divu, 1: div, 2: remu, 3: rem.
Tag_DI  in  C_TAG_WIDTH  tag captured on accept.
InVld_SI  in  1  request valid.
InRdy_SO  out  1  block can accept a request.
Flush_SI  in  1  abort the current operation.
OutVld_SO  out  1  result valid.
OutRdy_SI  in  1  consumer accepts the result.
Res_DO  out  C_WIDTH  quotient or remainder.
Tag_DO  out  C_TAG_WIDTH  tag of the current result.

Behaviour:
- Reset: state IDLE. All data registers, counter and flags are 0. InRdy_SO=1, OutVld_SO=0, Res_DO=0, Tag_DO=0.
- FSM states: IDLE, DIVIDE, FINISH.
  - InRdy_SO=1 only in IDLE. OutVld_SO=1 only in FINISH.
  - Res_DO and Tag_DO hold stable throughout FINISH.
- Accept: when InVld_SI & InRdy_SO & ~Flush_SI at cycle T, capture the following:
  - Tag.
  - Rem-select = OpCode[1].
  - Signed = OpCode[0].
  - |A| and |B|: two's-complement negation when signed and MSB=1. Magnitudes are unsigned C_WIDTH, so the most negative value maps to 2^(C_WIDTH-1).
  - Quotient-negate = signed & (A.msb ^ B.msb) & (B≠0).
  - Remainder-negate = signed & A.msb.
- Shift: S = lzc(|B|) - lzc(|A|).
- Early-out: if B=0, or |A|=0, or S<0, go IDLE→FINISH. OutVld_SO is asserted at T+1.
  - B=0: quotient = all ones; remainder = A unchanged.
  - |A| < |B|: quotient = 0; remainder = A.
- Normal path:
  - Divisor register = |B| << S; counter = S.
  - DIVIDE lasts S+1 cycles. Each cycle:
    - if rem ≥ divisor, subtract and shift in 1; otherwise shift in 0;
    - divisor shifts right logically;
    - counter decrements.
  - Leave DIVIDE when counter = 0 in that cycle; FINISH is entered at T+S+2.
- Output: Res_DO is the quotient or remainder per rem-select, two's-complement negated if the matching negate flag is set.
  - Overflow case needs no special logic: MIN / -1 yields MIN, and the remainder is 0.
- FINISH → IDLE on OutRdy_SI. No new request is accepted in that same cycle; the earliest next accept is the following cycle.
- Flush_SI:
  - In any state, the next state is IDLE and no result is produced.
  - It overrides OutRdy_SI and InVld_SI in the same cycle; nothing is accepted.
  - Data registers may retain stale values; Res_DO/Tag_DO are don't-care while OutVld_SO=0.
- Asynchronous reset mid-operation returns immediately to reset values; the operation is lost.
- Inputs are sampled only on the accept cycle. Changing them during DIVIDE or FINISH has no effect.

Test Plan:
1. divu 100/7, tag 3, accepted at T → S=4, OutVld_SO at T+6, Res_DO=14, Tag_DO=3; remu same operands → 2.
2. div 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD (-3); rem → 0xFFFFFFFF (-1); div 7/-2 → -3; rem 7/-2 → 1.
3. divu 0x1234/0 → 0xFFFFFFFF at T+1; rem 0x1234/0 → 0x1234; div -5/0 → 0xFFFFFFFF.
4. div 0x80000000/0xFFFFFFFF → 0x80000000 after 32 DIVIDE cycles; rem → 0. divu 0xFFFFFFFF/1 → 0xFFFFFFFF, OutVld at T+33.
5. divu 3/10 → 0 at T+1; remu → 3. Hold OutRdy_SI low for 4 cycles → Res_DO/Tag_DO stable and InRdy_SO=0 throughout; release → IDLE next cycle, back-to-back request accepted.
6. Flush_SI pulsed on the 3rd DIVIDE cycle of divu 1000/3 → IDLE next cycle, no OutVld_SO. Next request divu 9/3 → 3. Flush_SI together with InVld_SI in IDLE → not accepted.
